// File: rtl/aes_access_arbiter_if.sv
// Bus bundle between the AES access arbiter, its two requesters, the AES core
// and the scan-test controller.
interface aes_access_arbiter_if;
  logic         req0, encdec0, keylen0, ack0;
  logic [255:0] key0;
  logic [127:0] block0;
  logic         req1, encdec1, keylen1, ack1;
  logic [255:0] key1;
  logic [127:0] block1;
  logic [127:0] result;
  logic         core_init, core_next, core_encdec, core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready, core_result_valid;
  logic [127:0] core_result;
  logic         test_req, test_grant, key_scrub;

  modport slave (
    input  req0, encdec0, keylen0, key0, block0,
    input  req1, encdec1, keylen1, key1, block1,
    output ack0, ack1, result,
    output core_init, core_next, core_encdec, core_keylen, core_key, core_block,
    input  core_ready, core_result_valid, core_result,
    input  test_req,
    output test_grant, key_scrub
  );

  modport master (
    output req0, encdec0, keylen0, key0, block0,
    output req1, encdec1, keylen1, key1, block1,
    input  ack0, ack1, result,
    input  core_init, core_next, core_encdec, core_keylen, core_key, core_block,
    output core_ready, core_result_valid, core_result,
    output test_req,
    input  test_grant, key_scrub
  );
endinterface

// File: rtl/aes_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single AES core, with key
// caching and a key-scrubbing entry/exit path for scan test.
module aes_access_arbiter (
  input logic             clk,
  input logic             reset_n,
  aes_access_arbiter_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, KEYINIT, WAIT_KEY, NEXT, WAIT_RES, DONE, SCRUB, WAIT_SCRUB, TEST
  } state_t;

  state_t state, state_nxt;
  logic   first;

  logic [1:0]        req, encdec, keylen;
  logic [1:0][255:0] key;
  logic [1:0][127:0] block;

  logic         gnt, last_gnt, pick, hit;
  logic         job_encdec, job_keylen;
  logic [255:0] job_key;
  logic [127:0] job_block;
  logic         key_valid, key_len_q;
  logic [255:0] key_q;
  logic [127:0] result_q;

  logic       grant, key_set, res_load, scrubbing;
  logic       core_init, core_next, test_grant, key_scrub;
  logic [1:0] ack;

  assign req    = {bus.req1, bus.req0};
  assign encdec = {bus.encdec1, bus.encdec0};
  assign keylen = {bus.keylen1, bus.keylen0};
  assign key    = {bus.key1, bus.key0};
  assign block  = {bus.block1, bus.block0};

  // On a tie the requester not served last wins; last_gnt resets to 1 so 0 wins first.
  assign pick = (req == 2'b11) ? ~last_gnt : req[1];
  assign hit  = key_valid && (key[pick] == key_q) && (keylen[pick] == key_len_q);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      // Wait states ignore core_ready on the cycle they are entered.
      first <= (state_nxt != state);
    end
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    key_set    = 1'b0;
    res_load   = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    ack        = 2'b00;
    test_grant = 1'b0;
    key_scrub  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.test_req) state_nxt = SCRUB;
        else if (|req) begin
          grant     = 1'b1;
          state_nxt = hit ? NEXT : KEYINIT;
        end
      end
      KEYINIT: begin
        core_init = 1'b1;
        state_nxt = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (!first && bus.core_ready) begin
          key_set   = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        core_next = 1'b1;
        state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (!first && bus.core_ready && bus.core_result_valid) begin
          res_load  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack[gnt]  = 1'b1;
        state_nxt = IDLE;
      end
      SCRUB: begin
        core_init = 1'b1;
        key_scrub = 1'b1;
        state_nxt = WAIT_SCRUB;
      end
      WAIT_SCRUB: begin
        key_scrub = 1'b1;
        if (!first && bus.core_ready) state_nxt = bus.test_req ? TEST : IDLE;
      end
      TEST: begin
        test_grant = 1'b1;
        if (!bus.test_req) state_nxt = SCRUB;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      gnt        <= 1'b0;
      last_gnt   <= 1'b1;
      job_encdec <= 1'b0;
      job_keylen <= 1'b0;
      job_key    <= '0;
      job_block  <= '0;
    end else if (grant) begin
      gnt        <= pick;
      last_gnt   <= pick;
      job_encdec <= encdec[pick];
      job_keylen <= keylen[pick];
      job_key    <= key[pick];
      job_block  <= block[pick];
    end
  end

  // Key cache: loaded on KEYINIT, validated once the core finishes expansion.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      key_valid <= 1'b0;
      key_len_q <= 1'b0;
      key_q     <= '0;
    end else if (state == KEYINIT) begin
      key_valid <= 1'b0;
      key_len_q <= job_keylen;
      key_q     <= job_key;
    end else if (state == SCRUB) begin
      key_valid <= 1'b0;
      key_len_q <= 1'b0;
      key_q     <= '0;
    end else if (key_set) begin
      key_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)       result_q <= '0;
    else if (res_load) result_q <= bus.core_result;
  end

  assign scrubbing = (state == SCRUB) || (state == WAIT_SCRUB) || (state == TEST);

  assign bus.core_init   = core_init;
  assign bus.core_next   = core_next;
  assign bus.core_encdec = scrubbing ? 1'b0 : job_encdec;
  assign bus.core_keylen = scrubbing ? 1'b0 : job_keylen;
  assign bus.core_key    = scrubbing ? '0 : job_key;
  assign bus.core_block  = scrubbing ? '0 : job_block;
  assign bus.ack0        = ack[0];
  assign bus.ack1        = ack[1];
  assign bus.result      = result_q;
  assign bus.test_grant  = test_grant;
  assign bus.key_scrub   = key_scrub;
endmodule

// File: tb/tb_aes_access_arbiter.sv
// Bench for aes_access_arbiter: vector table of single jobs plus hand-written
// round-robin, scan-test and mid-job reset sequences against a stub AES core.
module tb_aes_access_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_access_arbiter_if bus();
  aes_access_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic         id;
    logic         enc;
    logic         len;
    logic [255:0] key;
    logic [127:0] blk;
    logic         exp_init;
  } vec_t;
  typedef struct {
    logic         id;
    logic [127:0] res;
  } ev_t;

  localparam logic [255:0] K1 = {4{64'h0123456789abcdef}};
  localparam logic [255:0] K2 = K1 ^ (256'h1 << 255);
  localparam logic [255:0] KA = {8{32'hdeadbeef}};
  localparam logic [255:0] KB = {8{32'h13572468}};
  localparam logic [255:0] K3 = {16{16'hc0de}};

  ev_t  exp_q[$];
  ev_t  act_q[$];
  vec_t vecs[6];
  int   checks = 0, failures = 0;
  int   init_cnt = 0, next_cnt = 0, overlap = 0;

  function automatic logic [127:0] model(input logic [255:0] k, input logic [127:0] b,
                                         input logic e, input logic l);
    logic [127:0] ek, lk;
    ek = e ? {4{32'h5a5a5a5a}} : '0;
    lk = l ? (128'h1 << 64) : '0;
    return b ^ k[127:0] ^ k[255:128] ^ ek ^ lk;
  endfunction

  // Stub core: ready drops on init/next and returns three cycles later.
  logic         rdy = 1'b1, had_next = 1'b0;
  int           cnt = 0;
  logic [127:0] cres = '0;
  always @(posedge clk) begin
    if (bus.core_init || bus.core_next) begin
      cnt      <= 3;
      rdy      <= 1'b0;
      had_next <= bus.core_next;
      if (bus.core_next)
        cres <= model(bus.core_key, bus.core_block, bus.core_encdec, bus.core_keylen);
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) rdy <= 1'b1;
    end
  end
  assign bus.core_ready        = rdy;
  assign bus.core_result_valid = rdy & had_next;
  assign bus.core_result       = cres;

  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) act_q.push_back('{id: bus.ack1, res: bus.result});
    if (bus.core_init) init_cnt <= init_cnt + 1;
    if (bus.core_next) next_cnt <= next_cnt + 1;
    if ((bus.core_init && bus.core_next) || (bus.ack0 && bus.ack1)) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic ev_t expect_of(input vec_t v);
    ev_t r;
    r.id  = v.id;
    r.res = model(v.key, v.blk, v.enc, v.len);
    return r;
  endfunction

  function automatic logic flag(input int sel);
    return (sel == 0) ? bus.key_scrub : bus.test_grant;
  endfunction

  task automatic drive(input vec_t v, input logic on);
    if (!v.id) begin
      bus.req0 = on; bus.encdec0 = v.enc; bus.keylen0 = v.len; bus.key0 = v.key; bus.block0 = v.blk;
    end else begin
      bus.req1 = on; bus.encdec1 = v.enc; bus.keylen1 = v.len; bus.key1 = v.key; bus.block1 = v.blk;
    end
  endtask

  task automatic wait_ack(input string name);
    int  n;
    ev_t a, e;
    n = 0;
    while (act_q.size() == 0 && n < 80) begin tick(); n++; end
    if (act_q.size() == 0) chk({name, "_ack_timeout"}, 0, 1);
    else if (exp_q.size() == 0) begin
      a = act_q.pop_front();
      chk({name, "_unexpected_ack"}, 1, 0);
    end else begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_ack_id"}, a.id, e.id);
      chk({name, "_result"}, a.res, e.res);
    end
  endtask

  task automatic wait_flag(input int sel, input logic val, input string name);
    int n;
    n = 0;
    while (flag(sel) !== val && n < 40) begin tick(); n++; end
    chk(name, flag(sel), val);
  endtask

  task automatic run_job(input vec_t v, input string name);
    int i0, n0;
    i0 = init_cnt;
    n0 = next_cnt;
    drive(v, 1'b1);
    exp_q.push_back(expect_of(v));
    tick();
    chk({name, "_init_first"}, bus.core_init, v.exp_init);
    chk({name, "_next_first"}, bus.core_next, !v.exp_init);
    wait_ack(name);
    drive(v, 1'b0);
    chk({name, "_init_count"}, init_cnt - i0, v.exp_init);
    chk({name, "_next_count"}, next_cnt - n0, 1);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, vc;
    int   i0, n0, n;
    vecs[0] = '{1'b0, 1'b1, 1'b1, K1, 128'h00112233445566778899aabbccddeeff, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, K1, 128'hffeeddccbbaa99887766554433221100, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, K1, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, K1, 128'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, K2, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, K2, 128'hcafef00d, 1'b0};
    va = '{1'b0, 1'b1, 1'b1, KA, 128'haaaa5555, 1'b0};
    vb = '{1'b1, 1'b0, 1'b1, KB, 128'h5555aaaa, 1'b0};
    vc = '{1'b0, 1'b1, 1'b1, K3, 128'h77, 1'b1};

    bus.req0 = 0; bus.encdec0 = 0; bus.keylen0 = 0; bus.key0 = '0; bus.block0 = '0;
    bus.req1 = 0; bus.encdec1 = 0; bus.keylen1 = 0; bus.key1 = '0; bus.block1 = '0;
    bus.test_req = 0;
    reset_n = 1'b1;
    tick();
    chk("rst_ctrl", {bus.ack0, bus.ack1, bus.core_init, bus.core_next, bus.test_grant, bus.key_scrub}, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_core_key", bus.core_key, 0);
    chk("rst_core_block", {bus.core_block, bus.core_encdec, bus.core_keylen}, 0);
    reset_n = 1'b0;
    tick();

    foreach (vecs[i]) run_job(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held from reset: 0, 1, 0, each with a fresh key expansion.
    do_reset();
    i0 = init_cnt;
    drive(va, 1'b1);
    drive(vb, 1'b1);
    exp_q.push_back(expect_of(va));
    exp_q.push_back(expect_of(vb));
    exp_q.push_back(expect_of(va));
    wait_ack("rr0");
    wait_ack("rr1");
    wait_ack("rr2");
    drive(va, 1'b0);
    drive(vb, 1'b0);
    chk("rr_init_count", init_cnt - i0, 3);
    tick();

    // Scan-test request during WAIT_RES: job finishes, scrub, test, exit scrub.
    drive(va, 1'b1);
    exp_q.push_back(expect_of(va));
    n0 = next_cnt;
    n  = 0;
    while (next_cnt == n0 && n < 40) begin tick(); n++; end
    chk("tm_next_seen", next_cnt != n0, 1);
    bus.test_req = 1'b1;
    wait_ack("tm_job");
    drive(va, 1'b0);
    wait_flag(0, 1'b1, "tm_scrub_on");
    chk("tm_scrub_key", bus.core_key, 0);
    chk("tm_scrub_init", bus.core_init, 1);
    chk("tm_scrub_block", bus.core_block, 0);
    wait_flag(1, 1'b1, "tm_grant");
    chk("tm_grant_scrub", bus.key_scrub, 0);
    drive(vb, 1'b1);
    repeat (8) tick();
    chk("tm_req_ignored", act_q.size(), 0);
    chk("tm_grant_held", {bus.test_grant, bus.core_init, bus.core_next}, 3'b100);
    drive(vb, 1'b0);
    bus.test_req = 1'b0;
    wait_flag(0, 1'b1, "tm_exit_scrub");
    chk("tm_exit_grant", bus.test_grant, 0);
    wait_flag(0, 1'b0, "tm_exit_done");
    va.exp_init = 1'b1;
    run_job(va, "tm_rekey");

    // Reset in WAIT_KEY abandons the job; the same job restarts at KEYINIT.
    drive(vc, 1'b1);
    tick();
    chk("rk_keyinit", bus.core_init, 1);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rk_ctrl", {bus.ack0, bus.ack1, bus.core_init, bus.core_next, bus.test_grant, bus.key_scrub}, 0);
    chk("rk_result", bus.result, 0);
    chk("rk_core_key", bus.core_key, 0);
    tick();
    tick();
    chk("rk_no_ack", act_q.size(), 0);
    reset_n = 1'b0;
    exp_q.push_back(expect_of(vc));
    tick();
    chk("rk_restart_init", bus.core_init, 1);
    wait_ack("rk_job");
    drive(vc, 1'b0);
    tick();

    chk("overlap", overlap, 0);
    chk("sb_empty", exp_q.size() + act_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_access_arbiter.md
AES_ACCESS_ARBITER -- requirements
Module: aes_access_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-high (1 = reset asserted).
REQ-003 SHALL have per requester i in {0,1}: reqi in 1 job request; encdeci in 1 (1=encrypt); keyleni in 1 (1=256-bit); keyi in 256; blocki in 128; acki out 1 one-cycle job-done pulse.
REQ-004 SHALL have: result  out  128  last completed block, valid when any acki=1.
REQ-005 SHALL have core side: core_init out 1; core_next out 1; core_encdec out 1; core_keylen out 1; core_key out 256; core_block out 128; core_ready in 1; core_result_valid in 1; core_result in 128.
REQ-006 SHALL have test side: test_req in 1 scan-test entry request; test_grant out 1 core released for scan; key_scrub out 1 key-clearing in progress.

Function
REQ-007 SHALL implement FSM states IDLE, KEYINIT, WAIT_KEY, NEXT, WAIT_RES, DONE, SCRUB, WAIT_SCRUB, TEST.
REQ-008 IDLE: test_req=1 SHALL go to SCRUB; priority over any reqi in the same cycle.
REQ-009 IDLE, test_req=0, any reqi=1: SHALL grant one requester; capture encdec, keylen, key, block into job registers; go to NEXT on key hit, else KEYINIT.
REQ-010 Key hit SHALL mean key_valid=1, captured key equals stored key, captured keylen equals stored keylen (full 256-bit compare).
REQ-011 Arbitration SHALL be round-robin: both requesting grants the requester not granted last; after reset requester 0 wins first tie.
REQ-012 KEYINIT: core_init=1 for exactly one cycle; store key/keylen; go to WAIT_KEY.
REQ-013 WAIT_KEY: SHALL ignore core_ready in its first cycle; thereafter core_ready=1 sets key_valid=1 and goes to NEXT.
REQ-014 NEXT: core_next=1 for exactly one cycle; go to WAIT_RES.
REQ-015 WAIT_RES: SHALL ignore its first cycle; thereafter core_ready=1 and core_result_valid=1 captures core_result into result and goes to DONE.
REQ-016 DONE: ack of granted requester =1 for exactly one cycle; other ack =0; return to IDLE.
REQ-017 result SHALL hold its value until the next DONE capture.
REQ-018 core_encdec, core_keylen, core_key, core_block SHALL be driven from job registers in all states except SCRUB/WAIT_SCRUB/TEST, where all four are 0.
REQ-019 reqi changes after grant SHALL NOT affect the job in flight; requester holds reqi until acki, and reqi=1 in the DONE cycle is a new request.
REQ-020 SCRUB: core_init=1 one cycle with zero key; key_valid cleared; stored key zeroed; go to WAIT_SCRUB.
REQ-021 WAIT_SCRUB: same first-cycle-ignore as WAIT_KEY; core_ready=1 goes to TEST if test_req=1, else IDLE.
REQ-022 key_scrub SHALL be 1 in SCRUB and WAIT_SCRUB only.
REQ-023 TEST: test_grant=1; all reqi ignored; core_init/core_next=0; test_req=0 goes to SCRUB (exit scrub), then IDLE.
REQ-024 test_req asserted during a job SHALL NOT abort the job; it is serviced at the next IDLE.
REQ-025 core_init and core_next SHALL never be 1 in the same cycle.

Reset
REQ-026 reset_n=1 SHALL force IDLE immediately: all outputs 0, result=0, key_valid=0, stored key=0, round-robin pointer favours requester 0.
REQ-027 Reset mid-job SHALL abandon the job with no ack.

Verification
REQ-028 req0=1, key K1, block P, core_ready returns after 3 cycles -> one core_init, then one core_next, ack0 pulse 1 cycle, result=core_result.
REQ-029 Second req0 with same K1/keylen -> no core_init, core_next one cycle after grant.
REQ-030 req0 and req1 asserted together from reset, held -> order ack0, ack1, ack0; K differs each switch -> core_init each job.
REQ-031 test_req raised during WAIT_RES -> job completes with ack; then key_scrub=1, core_key=0, test_grant=1; after test_req drop second scrub, then next job re-runs core_init (key_valid cleared).
REQ-032 reset_n=1 asserted in WAIT_KEY -> all outputs 0 same cycle, no ack; after release, identical job starts at KEYINIT.
